sha2_pad_unit: RTL
==================

# sha2_pad_unit

Parametrised SHA-2 input padding unit that supports SHA-224/256 (32-bit words) and SHA-384/512 (64-bit words).
- It accepts a message as a valid/ready stream of big-endian words, with a byte-granular last word.
- It emits a word stream of complete 16-word padded blocks: data words, the 0x80 pad byte, zero fill, then a 2-word bit-length field.
- It sits between the message deliverer and the hash engine's block register file.
- It processes back-to-back messages without reset.

## Interface
- `PKT_W`, default 32: word width in bits; legal values are 32 (SHA-256) and 64 (SHA-512). `NB = PKT_W/8` bytes per word. `BW = $clog2(NB)+1`.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst_b` in 1: reset, asynchronous, active-low.
- `pkt_vld` in 1: input word valid.
- `pkt_rdy` out 1: unit can accept an input word; a transfer occurs when `pkt_vld && pkt_rdy`.
- `pkt_data` in PKT_W: message word, big-endian; byte 0 is in the MSBs.
- `pkt_lst` in 1: this word is the last of the message.
- `pkt_bytes` in BW: valid byte count 0..NB of the last word; ignored when `pkt_lst`=0; 0 means empty trailing word, including the empty message.
- `out_vld` out 1: output word valid.
- `out_rdy` in 1: consumer accepts the output word; a transfer occurs when `out_vld && out_rdy`.
- `out_data` out PKT_W: padded block word.
- `out_idx` out 4: word index 0..15 within the block.
- `out_blk_end` out 1: high when `out_idx`==15.
- `out_msg_end` out 1: high on the final word (length low) of the message.

## Operation
- **Output register.** A single output register holds `out_data`, `out_idx`, `out_blk_end` and `out_msg_end`.
  - Define "slot free" = `!out_vld || out_rdy`.
  - A word is loaded only when the slot is free; `out_vld` is set on load.
  - `out_vld` clears when the word transfers and nothing new is loaded in that cycle.
- **Internal state.** A 4-bit write pointer `wp` supplies `out_idx`; it increments on every load and wraps 15→0. A 2*PKT_W bit-length counter `len` accumulates message bits.
- **FSM states:** RX, PAD, ZERO, LEN_HI, LEN_LO. One word is loaded per cycle while the slot is free.
- **RX.**
  - `pkt_rdy` = slot free; it is combinational from `out_rdy`.
  - Accepting a word with `pkt_lst`=0 loads `pkt_data` and adds 8*NB to `len`; the state stays RX.
  - Accepting a word with `pkt_lst`=1 and k=`pkt_bytes` adds 8*k to `len`.
    - If k=NB: load `pkt_data` and go to PAD.
    - If k<NB: load bytes 0..k-1 of `pkt_data`, put 0x80 in byte k, and zero the remaining bytes (input bytes ≥k are ignored). Then go to LEN_HI if `wp`==13, else go to ZERO.
- **PAD.** Load 0x80 followed by zeros (e.g. 0x80000000). Go to LEN_HI if `wp`==13, else go to ZERO.
- **ZERO.** Load all-zero words. Go to LEN_HI after the word loaded at `wp`==13. A pad word landing at slot 14 or 15 therefore zero-fills the rest of that block, then a whole extra block through slot 13.
- **LEN_HI.** Load `len[2*PKT_W-1:PKT_W]` at slot 14.
- **LEN_LO.** Load `len[PKT_W-1:0]` at slot 15 with `out_msg_end`=1. Clear `len`, and return to RX with `wp` wrapped to 0.
- `pkt_rdy`=0 in every state except RX.
- `len` wraps modulo 2^(2*PKT_W); no overflow flag.
- **Output stability.** While `out_vld && !out_rdy`, all output fields hold stable.

## Timing
- **Reset values:**
  - `out_vld`=0, `out_data`=0, `out_idx`=0, `out_blk_end`=0, `out_msg_end`=0.
  - Internally: state RX, `wp`=0, `len`=0.
  - `pkt_rdy`=1 during and after reset.
- **Reset mid-message:** aborts immediately. The partial block is discarded, and the next accepted word starts a new message at `out_idx` 0.
- **Latency:** a word accepted at edge N is presented on `out_data` from edge N (visible in cycle N+1).
  - With `out_rdy` held high, throughput is one word per cycle.
  - The padding tail costs one cycle per word and does not depend on `pkt_vld`.
- **First word of the next message:** it can be accepted on the edge after LEN_LO loads, provided the slot is free.
- **Simultaneous unload and load:** the output register reloads in the same edge, so there is no bubble.
- **Backpressure:** `pkt_rdy` follows `out_rdy` combinationally in RX. The consumer must not make `out_rdy` depend on `pkt_vld`.

## Test plan
- **SHA-256 "abc":** one word 0x61626300, `pkt_lst`=1, `pkt_bytes`=3 → 16 words: word0 0x61626380, words 1..14 = 0, word15 = 0x00000018 with `out_msg_end`=1 and `out_blk_end`=1.
- **Empty message:** `pkt_lst`=1, `pkt_bytes`=0 → word0 0x80000000, words 1..15 = 0, `out_msg_end` on word 15.
- **Block boundary:**
  - 55-byte message (13 full words, then last word with `pkt_bytes`=3): one block; word13 ends in 0x80, word15 = 0x1B8.
  - 56-byte message: two blocks (32 words); word14 of block 1 = 0x80000000, word15 of block 2 = 0x1C0.
- **Backpressure:** hold `out_rdy`=0 for 3 cycles mid-message and mid-padding → `out_data`/`out_idx` stable, `pkt_rdy`=0, no word lost or duplicated; the sequence is identical to the no-stall run.
- **Back-to-back messages, then reset:** two messages ("abc", then the empty message) → the second starts at `out_idx` 0 with `len` restarted (word15 = 0). Asserting `rst_b` low mid-message → outputs return to reset values, and the next message pads correctly.
- **PKT_W=64 "abc":** word0 0x6162638000000000, word15 = 0x18, word14 = 0 (128-bit length field).

Source files
------------

// File: rtl/sha2_pad_unit.sv
// SHA-2 message padding unit: turns a byte-granular word stream into complete
// 16-word blocks carrying the 0x80 marker, zero fill and a 2-word bit length.
module sha2_pad_unit #(
  parameter int PKT_W = 32,
  parameter int NB    = PKT_W / 8,
  parameter int BW    = $clog2(NB) + 1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             pkt_vld,
  output logic             pkt_rdy,
  input  logic [PKT_W-1:0] pkt_data,
  input  logic             pkt_lst,
  input  logic [BW-1:0]    pkt_bytes,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [PKT_W-1:0] out_data,
  output logic [3:0]       out_idx,
  output logic             out_blk_end,
  output logic             out_msg_end
);

  localparam int LW = 2 * PKT_W;

  localparam logic [2:0] ST_RX     = 3'd0;
  localparam logic [2:0] ST_PAD    = 3'd1;
  localparam logic [2:0] ST_ZERO   = 3'd2;
  localparam logic [2:0] ST_LEN_HI = 3'd3;
  localparam logic [2:0] ST_LEN_LO = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [3:0]       wp_q, wp_d;
  logic [LW-1:0]    len_q, len_d;
  logic             out_vld_q, out_vld_d;
  logic [PKT_W-1:0] out_data_q, out_data_d;
  logic [3:0]       out_idx_q, out_idx_d;
  logic             out_blk_end_q, out_blk_end_d;
  logic             out_msg_end_q, out_msg_end_d;

  logic             slot_free;
  logic             load;
  logic             wp_at_13;
  logic [PKT_W-1:0] ld_data;
  logic             ld_msg_end;
  logic [PKT_W-1:0] last_word;

  assign slot_free = !out_vld_q || out_rdy;
  assign wp_at_13  = (wp_q == 4'd13);
  assign pkt_rdy   = (state_q == ST_RX) && slot_free;

  // Final word: keep bytes below the count, marker at the count, zeros after.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_byte
      localparam int HI = PKT_W - 1 - 8 * gi;
      assign last_word[HI -: 8] = (BW'(gi) < pkt_bytes)  ? pkt_data[HI -: 8] :
                                  (BW'(gi) == pkt_bytes) ? 8'h80 : 8'h00;
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    load       = 1'b0;
    ld_data    = '0;
    ld_msg_end = 1'b0;
    if (slot_free) begin
      case (state_q)
        ST_RX: begin
          if (pkt_vld) begin
            load = 1'b1;
            if (!pkt_lst) begin
              ld_data = pkt_data;
              len_d   = len_q + LW'(8 * NB);
            end else begin
              len_d = len_q + {{(LW - BW - 3){1'b0}}, pkt_bytes, 3'b000};
              if (pkt_bytes == BW'(NB)) begin
                ld_data = pkt_data;
                state_d = ST_PAD;
              end else begin
                ld_data = last_word;
                state_d = wp_at_13 ? ST_LEN_HI : ST_ZERO;
              end
            end
          end
        end
        ST_PAD: begin
          load    = 1'b1;
          ld_data = {8'h80, {(PKT_W - 8){1'b0}}};
          state_d = wp_at_13 ? ST_LEN_HI : ST_ZERO;
        end
        ST_ZERO: begin
          load = 1'b1;
          if (wp_at_13) state_d = ST_LEN_HI;
        end
        ST_LEN_HI: begin
          load    = 1'b1;
          ld_data = len_q[LW-1:PKT_W];
          state_d = ST_LEN_LO;
        end
        ST_LEN_LO: begin
          load       = 1'b1;
          ld_data    = len_q[PKT_W-1:0];
          ld_msg_end = 1'b1;
          len_d      = '0;
          state_d    = ST_RX;
        end
        default: state_d = ST_RX;
      endcase
    end
  end

  always_comb begin
    wp_d          = wp_q;
    out_vld_d     = out_vld_q;
    out_data_d    = out_data_q;
    out_idx_d     = out_idx_q;
    out_blk_end_d = out_blk_end_q;
    out_msg_end_d = out_msg_end_q;
    if (load) begin
      wp_d          = wp_q + 4'd1;
      out_vld_d     = 1'b1;
      out_data_d    = ld_data;
      out_idx_d     = wp_q;
      out_blk_end_d = (wp_q == 4'd15);
      out_msg_end_d = ld_msg_end;
    end else if (out_rdy) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q       <= ST_RX;
      wp_q          <= '0;
      len_q         <= '0;
      out_vld_q     <= 1'b0;
      out_data_q    <= '0;
      out_idx_q     <= '0;
      out_blk_end_q <= 1'b0;
      out_msg_end_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wp_q          <= wp_d;
      len_q         <= len_d;
      out_vld_q     <= out_vld_d;
      out_data_q    <= out_data_d;
      out_idx_q     <= out_idx_d;
      out_blk_end_q <= out_blk_end_d;
      out_msg_end_q <= out_msg_end_d;
    end
  end

  assign out_vld     = out_vld_q;
  assign out_data    = out_data_q;
  assign out_idx     = out_idx_q;
  assign out_blk_end = out_blk_end_q;
  assign out_msg_end = out_msg_end_q;

endmodule
